// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the serial sequence generator.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10
  } state_t;

  localparam logic [3:0] PAT_1010 = 4'b1010;

  // A zero or oversized length means "send the whole pattern".
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned pat_w);
    return ((len == 0) || (len > pat_w)) ? pat_w : len;
  endfunction

endpackage

// File: rtl/seq_gen_shifter.sv
// Holds the latched pattern, its effective length and the current bit index.
// Exposes the bits the transmitter may present next so it can register them.
module seq_gen_shifter
  import seq_gen_pkg::*;
#(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             restart,
  input  logic             advance,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             load_bit_c,
  output logic             next_bit_c,
  output logic             first_bit_c,
  output logic             last_bit_c
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [LEN_W-1:0] load_len;
  logic [PAT_W-1:0] load_sh;
  logic [PAT_W-1:0] next_sh;
  logic [PAT_W-1:0] first_sh;

  // Bit selection through shifts keeps index widths independent of PAT_W.
  always_comb begin
    load_len    = LEN_W'(eff_len(32'(len), PAT_W));
    load_sh     = pattern >> (load_len - ONE);
    next_sh     = pat_q >> (idx_q - ONE);
    first_sh    = pat_q >> (len_q - ONE);
    load_bit_c  = load_sh[0];
    next_bit_c  = next_sh[0];
    first_bit_c = first_sh[0];
    last_bit_c  = (idx_q == '0);
  end

  // Pattern capture and MSB-first index walk.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else if (load) begin
      pat_q <= pattern;
      len_q <= load_len;
      idx_q <= load_len - ONE;
    end else if (restart) begin
      idx_q <= len_q - ONE;
    end else if (advance) begin
      idx_q <= idx_q - ONE;
    end
  end

endmodule

// File: rtl/seq_gen_tx.sv
// Serial pattern transmitter: repeats a latched pattern MSB-first over a
// valid/ready bit interface with optional idle gaps between frames.
module seq_gen_tx
  import seq_gen_pkg::*;
#(
  parameter int unsigned PAT_W    = 8,
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned GAP_CYC  = 0,
  parameter logic        IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       repeat_cnt,
  input  logic             bit_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      GAP_W    = (GAP_CYC != 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC != 0) ? GAP_CYC - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  state_t           state_q, state_d;
  logic [7:0]       frame_q, frame_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             bit_out_d, bit_valid_d, frame_start_d, busy_d, done_d;
  logic             load, restart, advance, xfer;
  logic             load_bit_c, next_bit_c, first_bit_c, last_bit_c;

  seq_gen_shifter #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .restart    (restart),
    .advance    (advance),
    .pattern    (pattern),
    .len        (len),
    .load_bit_c (load_bit_c),
    .next_bit_c (next_bit_c),
    .first_bit_c(first_bit_c),
    .last_bit_c (last_bit_c)
  );

  assign xfer = bit_valid & bit_ready;

  // Next-state and next-output logic; outputs hold unless a decision changes them.
  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    gap_d         = gap_q;
    bit_out_d     = bit_out;
    bit_valid_d   = bit_valid;
    frame_start_d = frame_start;
    busy_d        = busy;
    done_d        = 1'b0;
    load          = 1'b0;
    restart       = 1'b0;
    advance       = 1'b0;

    if (abort && (state_q != IDLE)) begin
      state_d       = IDLE;
      bit_out_d     = IDLE_LVL;
      bit_valid_d   = 1'b0;
      frame_start_d = 1'b0;
      busy_d        = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_out_d     = IDLE_LVL;
          bit_valid_d   = 1'b0;
          frame_start_d = 1'b0;
          busy_d        = 1'b0;
          if (start) begin
            load          = 1'b1;
            state_d       = SEND;
            frame_d       = repeat_cnt;
            bit_out_d     = load_bit_c;
            bit_valid_d   = 1'b1;
            frame_start_d = 1'b1;
            busy_d        = 1'b1;
          end
        end
        SEND: begin
          if (xfer) begin
            if (!last_bit_c) begin
              advance       = 1'b1;
              bit_out_d     = next_bit_c;
              frame_start_d = 1'b0;
            end else if (frame_q != 8'd0) begin
              restart = 1'b1;
              frame_d = frame_q - 8'd1;
              if (GAP_CYC != 0) begin
                state_d       = GAP;
                gap_d         = GAP_LAST;
                bit_out_d     = IDLE_LVL;
                bit_valid_d   = 1'b0;
                frame_start_d = 1'b0;
              end else begin
                bit_out_d     = first_bit_c;
                frame_start_d = 1'b1;
              end
            end else begin
              state_d       = IDLE;
              bit_out_d     = IDLE_LVL;
              bit_valid_d   = 1'b0;
              frame_start_d = 1'b0;
              busy_d        = 1'b0;
              done_d        = 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            state_d       = SEND;
            bit_out_d     = first_bit_c;
            bit_valid_d   = 1'b1;
            frame_start_d = 1'b1;
          end else begin
            gap_d = gap_q - GAP_ONE;
          end
        end
        default: begin
          state_d       = IDLE;
          bit_out_d     = IDLE_LVL;
          bit_valid_d   = 1'b0;
          frame_start_d = 1'b0;
          busy_d        = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      gap_q       <= '0;
      bit_out     <= IDLE_LVL;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      gap_q       <= gap_d;
      bit_out     <= bit_out_d;
      bit_valid   <= bit_valid_d;
      frame_start <= frame_start_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: doc/seq_gen_tx.md
Name: seq_gen_tx

Overview:
Serial pattern transmitter; the generating end of the team's serial sequence-detection path. Captures a parallel pattern, length and repeat count on a start pulse. Emits the pattern MSB-first, one bit per transfer, over a valid/ready serial interface. Drives the A-input side of the sequence detectors and their benches with repeatable, gap-controlled bit streams.

Parameters:
PAT_W, 8, maximum pattern width in bits (≥2)
LEN_W, 4, width of len port; must satisfy 2^LEN_W > PAT_W
GAP_CYC, 0, idle cycles inserted between repeated frames (0 = back-to-back)
IDLE_LVL, 1'b0, value driven on bit_out whenever bit_valid=0

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low; clock clk
start  in  1  request; sampled only in IDLE
abort  in  1  synchronous cancel of current transmission
pattern  in  PAT_W  bits to send; bit len-1 goes first
len  in  LEN_W  frame length in bits
repeat_cnt  in  8  extra frames; total frames = repeat_cnt+1
bit_ready  in  1  sink accepts bit this cycle
bit_out  out  1  serial data
bit_valid  out  1  bit_out holds a bit to transfer
frame_start  out  1  high while first bit of a frame is presented
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after final bit transfers

Behaviour:
- Reset (rst=0 at posedge, overrides everything): state IDLE; bit_out=IDLE_LVL; bit_valid=0, frame_start=0, busy=0, done=0; internal counters cleared. Reset mid-frame discards the frame with no done.
- States: IDLE, SEND, GAP. All outputs registered.
- Transfer: occurs at a posedge with bit_valid=1 and bit_ready=1. bit_out and bit_valid stay stable until transfer. No combinational path from bit_ready to outputs.
- IDLE: start=1 at edge N latches pattern, len, repeat_cnt.
  - Effective length L = PAT_W if len=0 or len>PAT_W; else L = len.
  - After edge N: SEND, busy=1, bit_valid=1, frame_start=1, bit_out=pattern[L-1]. Latency is 1 cycle.
- SEND: each transfer decrements the bit index and presents the next bit on the following cycle. frame_start clears after the first transfer of each frame.
  - Last bit transferred, frames remaining, GAP_CYC>0: go to GAP. bit_valid=0, bit_out=IDLE_LVL for exactly GAP_CYC cycles, then SEND with frame_start=1 and bit L-1.
  - Last bit transferred, frames remaining, GAP_CYC=0: first bit of the next frame is presented the very next cycle.
  - Last bit of final frame transferred: next cycle state IDLE, bit_valid=0, busy=0, done=1 for one cycle.
- start while busy=1: ignored; latched inputs unchanged. Input changes after capture have no effect.
- start in the same cycle done=1: state is IDLE, so start is accepted. Back-to-back jobs are legal.
- abort=1 (rst=1) at any edge in SEND/GAP: next cycle IDLE, bit_valid=0, busy=0, frame_start=0, done=0. abort in IDLE has no effect. abort outranks start in the same cycle.
- Counters: bit index uses LEN_W bits. Frame counter is 8-bit down-counter, no wrap (repeat_cnt=255 gives 256 frames). Gap counter is width clog2(GAP_CYC+1).

Decomposition:
- Package seq_gen_pkg: state enum (IDLE=2'b00, SEND=2'b01, GAP=2'b10), default pattern constant PAT_1010=4'b1010, function for effective-length clamp.
- One natural sub-module, seq_gen_shifter: holds the latched pattern and bit index. Provides load, advance on transfer, current bit, and last-bit flag.
- seq_gen_tx keeps the FSM, frame/gap counters and output registers.

Test Plan:
1. PAT_W=4, pattern=4'b1010, len=4, repeat_cnt=0, bit_ready=1, start one cycle. Expect bit_out 1,0,1,0 on 4 consecutive valid cycles; frame_start on the first only; done one cycle after the 4th transfer; busy spans start+1 to done.
2. Same pattern, repeat_cnt=2, GAP_CYC=2. Expect 3 frames of 1010 separated by exactly 2 cycles of bit_valid=0/bit_out=0; 12 transfers; single done.
3. Backpressure: bit_ready low for 3 cycles while the 2nd bit (0) is presented. Expect bit_out=0, bit_valid=1 held 4 cycles; sequence still 1010; done delayed by 3 cycles.
4. len=0 and len=15 with PAT_W=8, pattern=8'hA5. Expect 8 bits 1,0,1,0,0,1,0,1 in both cases.
5. abort asserted after the 2nd transfer of a repeat_cnt=3 job. Expect bit_valid=0, busy=0 next cycle, no done pulse. A start 1 cycle later restarts cleanly from bit L-1.
6. rst=0 for one cycle mid-GAP, plus start pulsed while busy in a separate run. Reset case: all outputs at reset values next cycle, no done. Busy case: ignored start leaves stream and latched pattern unchanged.
